// File: rtl/triram_arbiter.sv
// triram_arbiter: shares one triram between an instruction-fetch port (0)
// and a data port (1). Round-robin arbitration, one outstanding access at a
// time, watchdog abort for accesses that never complete. All outputs are
// registered; the block is a four-state FSM (IDLE/ISSUE/WAIT/RESP).
module triram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // port 0: instruction fetch
  input  logic        r0_req,
  input  logic        r0_write,
  input  logic [1:0]  r0_pt,
  input  logic [17:0] r0_addr,
  input  logic [17:0] r0_in,
  output logic        r0_ack,
  output logic        r0_o,
  output logic        r0_pagefault,
  output logic [17:0] r0_out,
  // port 1: data
  input  logic        r1_req,
  input  logic        r1_write,
  input  logic [1:0]  r1_pt,
  input  logic [17:0] r1_addr,
  input  logic [17:0] r1_in,
  output logic        r1_ack,
  output logic        r1_o,
  output logic        r1_pagefault,
  output logic [17:0] r1_out,
  // shared triram
  output logic        m_e,
  output logic        m_write,
  output logic [1:0]  m_pt,
  output logic [17:0] m_addr,
  output logic [17:0] m_in,
  input  logic        m_o,
  input  logic        m_pagefault,
  input  logic [17:0] m_out,
  // status
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Every registered output and piece of bookkeeping in one record so the
  // output logic can compute a complete next value in a single place.
  typedef struct packed {
    logic        m_e;
    logic        m_write;
    logic [1:0]  m_pt;
    logic [17:0] m_addr;
    logic [17:0] m_in;
    logic        owner;    // port that owns the current access
    logic        last;     // port granted most recently
    logic [7:0]  cnt;      // watchdog counter, counts WAIT cycles
    logic [1:0]  ack;      // one-cycle grant pulse per port
    logic [1:0]  o;        // one-cycle completion pulse per port
    logic [1:0]  pf;       // pagefault per port, held between responses
    logic [17:0] out0;
    logic [17:0] out1;
    logic        timeout;  // sticky watchdog flag
    logic        busy;
  } regs_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t state_q, state_d;
  regs_t  r_q, r_d;
  logic   grant_valid;
  logic   grant_port;

  // Round-robin choice: a lone request wins outright, a tie goes to the port
  // that was not served last.
  always_comb begin
    grant_valid = r0_req | r1_req;
    if (r0_req && r1_req) grant_port = ~r_q.last;
    else                  grant_port = r1_req;
  end

  // State register; reset drops the in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_o || r_q.cnt == TMAX) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next value of every registered output, derived from the current state.
  always_comb begin
    // NOTE: starting from the held value and then overriding pulses gives
    // every field a value on every path, so no latch can be inferred.
    r_d      = r_q;
    r_d.m_e  = 1'b0;
    r_d.ack  = 2'b00;
    r_d.o    = 2'b00;
    r_d.busy = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          r_d.owner   = grant_port;
          r_d.last    = grant_port;
          r_d.ack     = grant_port ? 2'b10 : 2'b01;
          r_d.m_e     = 1'b1;
          r_d.m_write = grant_port ? r1_write : r0_write;
          r_d.m_pt    = grant_port ? r1_pt    : r0_pt;
          r_d.m_addr  = grant_port ? r1_addr  : r0_addr;
          r_d.m_in    = grant_port ? r1_in    : r0_in;
        end
      end
      ISSUE: begin
        r_d.cnt = 8'd0;
      end
      WAIT: begin
        if (m_o) begin
          if (r_q.owner) begin
            r_d.out1  = m_out;
            r_d.pf[1] = m_pagefault;
            r_d.o     = 2'b10;
          end else begin
            r_d.out0  = m_out;
            r_d.pf[0] = m_pagefault;
            r_d.o     = 2'b01;
          end
        end else if (r_q.cnt == TMAX) begin
          // Watchdog abort: report a pagefault with zero data.
          r_d.timeout = 1'b1;
          if (r_q.owner) begin
            r_d.out1  = 18'd0;
            r_d.pf[1] = 1'b1;
            r_d.o     = 2'b10;
          end else begin
            r_d.out0  = 18'd0;
            r_d.pf[0] = 1'b1;
            r_d.o     = 2'b01;
          end
        end else begin
          r_d.cnt = r_q.cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; all clear on reset except last, so port 0 wins the
  // first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this is a small set of control/data flops, not a memory array,
      // so resetting all of it is cheap and gives defined outputs.
      r_q      <= '0;
      r_q.last <= 1'b1;
    end else begin
      r_q <= r_d;
    end
  end

  assign m_e          = r_q.m_e;
  assign m_write      = r_q.m_write;
  assign m_pt         = r_q.m_pt;
  assign m_addr       = r_q.m_addr;
  assign m_in         = r_q.m_in;
  assign r0_ack       = r_q.ack[0];
  assign r1_ack       = r_q.ack[1];
  assign r0_o         = r_q.o[0];
  assign r1_o         = r_q.o[1];
  assign r0_pagefault = r_q.pf[0];
  assign r1_pagefault = r_q.pf[1];
  assign r0_out       = r_q.out0;
  assign r1_out       = r_q.out1;
  assign busy         = r_q.busy;
  assign timeout      = r_q.timeout;

endmodule

// File: tb/tb_triram_arbiter.sv
// Directed testbench for triram_arbiter. A small behavioural triram stub
// answers one cycle after m_e (or never, when stalled); expected values are
// hand-computed in the vector table and the tie/reset sequences.
module tb_triram_arbiter;

  localparam logic [17:0] WORD0 = 18'b111111000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r0_write = 1'b0;
  logic [1:0]  r0_pt = 2'b00;
  logic [17:0] r0_addr = '0, r0_in = '0;
  logic        r1_req = 1'b0, r1_write = 1'b0;
  logic [1:0]  r1_pt = 2'b00;
  logic [17:0] r1_addr = '0, r1_in = '0;
  logic        r0_ack, r0_o, r0_pagefault, r1_ack, r1_o, r1_pagefault;
  logic [17:0] r0_out, r1_out;
  logic        m_e, m_write;
  logic [1:0]  m_pt;
  logic [17:0] m_addr, m_in;
  logic        m_o;
  logic        m_pagefault;
  logic [17:0] m_out;
  logic        busy, timeout;

  // stub controls
  logic        stall  = 1'b0;
  logic        pf_mem = 1'b0;
  logic [17:0] mem [16];

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_out_q [2];
  logic        exp_pf_q  [2];

  always #5 clk = ~clk;

  triram_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_write(r0_write), .r0_pt(r0_pt), .r0_addr(r0_addr), .r0_in(r0_in),
    .r0_ack(r0_ack), .r0_o(r0_o), .r0_pagefault(r0_pagefault), .r0_out(r0_out),
    .r1_req(r1_req), .r1_write(r1_write), .r1_pt(r1_pt), .r1_addr(r1_addr), .r1_in(r1_in),
    .r1_ack(r1_ack), .r1_o(r1_o), .r1_pagefault(r1_pagefault), .r1_out(r1_out),
    .m_e(m_e), .m_write(m_write), .m_pt(m_pt), .m_addr(m_addr), .m_in(m_in),
    .m_o(m_o), .m_pagefault(m_pagefault), .m_out(m_out),
    .busy(busy), .timeout(timeout)
  );

  // triram stub: answers one cycle after m_e unless stalled
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 18'd0;
      mem[0]      <= WORD0;
      m_o         <= 1'b0;
      m_pagefault <= 1'b0;
      m_out       <= 18'd0;
    end else begin
      m_o <= 1'b0;
      if (m_e && !stall) begin
        m_o         <= 1'b1;
        m_pagefault <= pf_mem;
        m_out       <= (m_write || pf_mem) ? 18'd0 : mem[m_addr[3:0]];
        if (m_write && !pf_mem) mem[m_addr[3:0]] <= m_in;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int          port;
    logic        write;
    logic [1:0]  pt;
    logic [17:0] addr;
    logic [17:0] din;
    logic        stall;
    logic        pf_mem;
    logic [17:0] exp_out;
    logic        exp_pf;
    int          exp_lat;
    logic        exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? r0_ack : r1_ack;
  endfunction
  function automatic logic o_of(input int p);
    return (p == 0) ? r0_o : r1_o;
  endfunction
  function automatic logic pf_of(input int p);
    return (p == 0) ? r0_pagefault : r1_pagefault;
  endfunction
  function automatic logic [17:0] out_of(input int p);
    return (p == 0) ? r0_out : r1_out;
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p == 0) r0_req = v;
    else        r1_req = v;
  endtask

  task automatic drive_cmd(input int p, input logic w, input logic [1:0] pt,
                           input logic [17:0] a, input logic [17:0] d);
    if (p == 0) begin
      r0_write = w; r0_pt = pt; r0_addr = a; r0_in = d;
    end else begin
      r1_write = w; r1_pt = pt; r1_addr = a; r1_in = d;
    end
  endtask

  // One isolated access on a single port, starting from IDLE.
  task automatic run_vec(input string tag, input vec_t v);
    int n;
    int extra_e;
    int q;
    q = 1 - v.port;
    stall  = v.stall;
    pf_mem = v.pf_mem;
    drive_cmd(v.port, v.write, v.pt, v.addr, v.din);
    set_req(v.port, 1'b1);
    tick();  // cycle 1
    check({tag, " ack"}, ack_of(v.port), 1);
    check({tag, " other ack"}, ack_of(q), 0);
    check({tag, " m_e"}, m_e, 1);
    check({tag, " busy"}, busy, 1);
    check({tag, " m_addr"}, m_addr, v.addr);
    check({tag, " m_write"}, m_write, v.write);
    check({tag, " m_pt"}, m_pt, v.pt);
    check({tag, " m_in"}, m_in, v.din);
    set_req(v.port, 1'b0);
    n = 1;
    extra_e = 0;
    while (!o_of(v.port) && n < 40) begin
      tick();
      n++;
      if (m_e) extra_e++;
    end
    check({tag, " latency"}, n, v.exp_lat);
    check({tag, " m_e single"}, extra_e, 0);
    check({tag, " out"}, out_of(v.port), v.exp_out);
    check({tag, " pagefault"}, pf_of(v.port), v.exp_pf);
    check({tag, " timeout"}, timeout, v.exp_to);
    check({tag, " other o"}, o_of(q), 0);
    check({tag, " other out"}, out_of(q), exp_out_q[q]);
    check({tag, " other pf"}, pf_of(q), exp_pf_q[q]);
    exp_out_q[v.port] = v.exp_out;
    exp_pf_q[v.port]  = v.exp_pf;
    tick();
    check({tag, " o pulse"}, o_of(v.port), 0);
    check({tag, " idle busy"}, busy, 0);
    stall = 1'b0;
    pf_mem = 1'b0;
  endtask

  // Both ports request a read of address 0 in the same cycle.
  task automatic tie(input string tag, input int first);
    int second;
    second = 1 - first;
    stall = 1'b0;
    pf_mem = 1'b0;
    drive_cmd(0, 1'b0, 2'b00, 18'd0, 18'd0);
    drive_cmd(1, 1'b0, 2'b00, 18'd0, 18'd0);
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick();  // cycle 1
    check({tag, " first ack"}, ack_of(first), 1);
    check({tag, " second no ack"}, ack_of(second), 0);
    set_req(first, 1'b0);
    tick();
    tick();  // cycle 3
    check({tag, " first o"}, o_of(first), 1);
    check({tag, " second no o"}, o_of(second), 0);
    check({tag, " first out"}, out_of(first), WORD0);
    tick();  // cycle 4
    check({tag, " idle gap"}, busy, 0);
    tick();  // cycle 5
    check({tag, " second ack"}, ack_of(second), 1);
    check({tag, " first no ack"}, ack_of(first), 0);
    set_req(second, 1'b0);
    tick();
    tick();  // cycle 7
    check({tag, " second o"}, o_of(second), 1);
    check({tag, " first no o"}, o_of(first), 0);
    check({tag, " second out"}, out_of(second), WORD0);
    tick();
    exp_out_q[0] = WORD0; exp_pf_q[0] = 1'b0;
    exp_out_q[1] = WORD0; exp_pf_q[1] = 1'b0;
  endtask

  initial begin
    vec_t vecs [6];
    vec_t single;
    int   seen_o;

    //          port wr  pt     addr       din        stall pf  exp_out    pf  lat to
    vecs[0] = '{0, 1'b0, 2'b00, 18'h00000, 18'h00000, 1'b0, 1'b0, WORD0,     1'b0, 3, 1'b0};
    vecs[1] = '{1, 1'b1, 2'b00, 18'h00001, 18'h15555, 1'b0, 1'b0, 18'h00000, 1'b0, 3, 1'b0};
    vecs[2] = '{0, 1'b0, 2'b00, 18'h00001, 18'h00000, 1'b0, 1'b0, 18'h15555, 1'b0, 3, 1'b0};
    vecs[3] = '{1, 1'b0, 2'b00, 18'h00002, 18'h00000, 1'b0, 1'b1, 18'h00000, 1'b1, 3, 1'b0};
    vecs[4] = '{0, 1'b0, 2'b11, 18'h00001, 18'h00000, 1'b1, 1'b0, 18'h00000, 1'b1, 6, 1'b1};
    vecs[5] = '{1, 1'b0, 2'b01, 18'h00001, 18'h00000, 1'b0, 1'b0, 18'h15555, 1'b0, 3, 1'b1};
    single  = '{0, 1'b0, 2'b00, 18'h00000, 18'h00000, 1'b0, 1'b0, WORD0,     1'b0, 3, 1'b0};

    exp_out_q[0] = '0; exp_out_q[1] = '0;
    exp_pf_q[0]  = 1'b0; exp_pf_q[1] = 1'b0;

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst m_e", m_e, 0);
    check("rst busy", busy, 0);
    check("rst timeout", timeout, 0);
    check("rst acks", {r0_ack, r1_ack}, 0);
    check("rst os", {r0_o, r1_o}, 0);
    check("rst pfs", {r0_pagefault, r1_pagefault}, 0);
    check("rst r0_out", r0_out, 0);
    check("rst r1_out", r1_out, 0);
    check("rst m_cmd", {m_write, m_pt, m_addr, m_in}, 0);

    // round robin: r0 wins the first tie; after a lone r0 access, r1 wins
    tie("tie1", 0);
    run_vec("rr single", single);
    tie("tie2", 1);

    // single accesses: read, write, read-back, pagefault, timeout, recovery
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // reset during WAIT drops the access with no response
    stall = 1'b1;
    drive_cmd(1, 1'b0, 2'b00, 18'd1, 18'd0);
    r1_req = 1'b1;
    tick();  // cycle 1
    check("rstwait ack", r1_ack, 1);
    r1_req = 1'b0;
    tick();
    tick();  // in WAIT
    check("rstwait busy before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstwait m_e", m_e, 0);
    check("rstwait busy", busy, 0);
    check("rstwait os", {r0_o, r1_o}, 0);
    check("rstwait timeout", timeout, 0);
    check("rstwait r1_out", r1_out, 0);
    tick();
    tick();
    rst = 1'b0;
    stall = 1'b0;
    exp_out_q[0] = '0; exp_out_q[1] = '0;
    exp_pf_q[0]  = 1'b0; exp_pf_q[1] = 1'b0;
    seen_o = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (r0_o || r1_o || busy) seen_o++;
    end
    check("rstwait no response", seen_o, 0);
    tie("tie after rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
